smi_dreq_sched: RTL

- Sequences the SMI DMA stream between the host and the modem datapath.
- Holds the radio stream mode (idle / RX / TX) loaded over SPI, and gates the RX framer and TX deframer enables.
- Generates o_smi_dreq in fixed-length bursts from the FIFO filling levels.
- Pulses a FIFO flush on every mode change and aborts bursts that stall.
- Sits between sys_ctrl/spi_if, the rx/tx afifo level outputs, and the SMI pins. Runs entirely in the system clock domain.

---
 rtl/smi_dreq_sched_if.sv | 26 ++
 rtl/smi_dreq_sched.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/smi_dreq_sched_if.sv
// SMI DMA scheduler bus: mode load, FIFO levels and SMI strobes in; DREQ, enables and status out.
`timescale 1ns/1ps
interface smi_dreq_sched_if #(parameter int LEVEL_W = 10);
  logic [1:0]         i_mode;
  logic               i_mode_load;
  logic [LEVEL_W-1:0] i_rx_level;
  logic [LEVEL_W-1:0] i_tx_level;
  logic               i_smi_soe_se;
  logic               i_smi_swe_srw;
  logic               o_smi_dreq;
  logic               o_rx_enable;
  logic               o_tx_enable;
  logic               o_flush;
  logic               o_timeout;
  logic [2:0]         o_state;
  logic [12:0]        o_burst_cnt;

  modport slave (
    input  i_mode, i_mode_load, i_rx_level, i_tx_level, i_smi_soe_se, i_smi_swe_srw,
    output o_smi_dreq, o_rx_enable, o_tx_enable, o_flush, o_timeout, o_state, o_burst_cnt
  );
  modport master (
    output i_mode, i_mode_load, i_rx_level, i_tx_level, i_smi_soe_se, i_smi_swe_srw,
    input  o_smi_dreq, o_rx_enable, o_tx_enable, o_flush, o_timeout, o_state, o_burst_cnt
  );
endinterface

// File: rtl/smi_dreq_sched.sv
// SMI DMA request scheduler: holds the stream mode, flushes on mode change and
// issues fixed-length DREQ bursts gated by FIFO watermarks, with stall abort.
`timescale 1ns/1ps
module smi_dreq_sched #(
  parameter int LEVEL_W      = 10,
  parameter int BURST_LEN    = 1024,
  parameter int RX_WM        = 256,
  parameter int TX_WM        = 500,
  parameter int FLUSH_CYCLES = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic i_sys_clk,
  input  logic i_rst_b,
  smi_dreq_sched_if.slave bus
);
  localparam int IW = $clog2(TIMEOUT);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [1:0] MODE_IDLE = 2'b00, MODE_RX = 2'b01, MODE_TX = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0, RX_WAIT = 3'd1, RX_BURST = 3'd2, TX_WAIT = 3'd3, TX_BURST = 3'd4, SWITCH = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      active_q, active_d, pending_q, pending_d;
  logic [12:0]     burst_cnt_q, burst_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            soe_q, swe_q;
  logic            dreq_q, dreq_d, rx_en_q, rx_en_d, tx_en_q, tx_en_d;
  logic            flush_q, flush_d, timeout_q, timeout_d;
  logic            chg, strb_rise;

  function automatic state_e mode_st(input logic [1:0] m);
    case (m)
      MODE_RX: mode_st = RX_WAIT;
      MODE_TX: mode_st = TX_WAIT;
      default: mode_st = IDLE;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pending_d   = pending_q;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = 1'b0;
    if (bus.i_mode_load) pending_d = (bus.i_mode == 2'b11) ? MODE_IDLE : bus.i_mode;
    chg = (pending_q != active_q);
    // only the strobe belonging to the active direction is watched
    strb_rise = (active_q == MODE_TX) ? (bus.i_smi_swe_srw & ~swe_q)
                                      : (bus.i_smi_soe_se  & ~soe_q);
    case (state_q)
      IDLE, RX_WAIT, TX_WAIT: begin
        if (chg) begin
          state_d     = SWITCH;
          flush_cnt_d = '0;
        end else if (state_q == RX_WAIT && bus.i_rx_level >= LEVEL_W'(RX_WM)) begin
          state_d     = RX_BURST;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
        end else if (state_q == TX_WAIT && bus.i_tx_level <= LEVEL_W'(TX_WM)) begin
          state_d     = TX_BURST;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
      RX_BURST, TX_BURST: begin
        if (strb_rise) begin
          burst_cnt_d = burst_cnt_q + 13'd1;
          idle_cnt_d  = '0;
          if (burst_cnt_q == 13'(BURST_LEN - 1))
            state_d = chg ? SWITCH : ((state_q == RX_BURST) ? RX_WAIT : TX_WAIT);
        end else if (idle_cnt_q == IW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = chg ? SWITCH : ((state_q == RX_BURST) ? RX_WAIT : TX_WAIT);
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (state_d == SWITCH) flush_cnt_d = '0;
      end
      SWITCH: begin
        if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
          active_d = pending_q;
          state_d  = mode_st(pending_q);
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // outputs are a registered decode of the next state
    dreq_d  = (state_d == RX_BURST) || (state_d == TX_BURST);
    rx_en_d = (state_d == RX_WAIT)  || (state_d == RX_BURST);
    tx_en_d = (state_d == TX_WAIT)  || (state_d == TX_BURST);
    flush_d = (state_d == SWITCH);
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q     <= IDLE;
      active_q    <= MODE_IDLE;
      pending_q   <= MODE_IDLE;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
      flush_cnt_q <= '0;
      soe_q       <= 1'b0;
      swe_q       <= 1'b0;
      dreq_q      <= 1'b0;
      rx_en_q     <= 1'b0;
      tx_en_q     <= 1'b0;
      flush_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      soe_q       <= bus.i_smi_soe_se;
      swe_q       <= bus.i_smi_swe_srw;
      dreq_q      <= dreq_d;
      rx_en_q     <= rx_en_d;
      tx_en_q     <= tx_en_d;
      flush_q     <= flush_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.o_smi_dreq  = dreq_q;
  assign bus.o_rx_enable = rx_en_q;
  assign bus.o_tx_enable = tx_en_q;
  assign bus.o_flush     = flush_q;
  assign bus.o_timeout   = timeout_q;
  assign bus.o_state     = state_q;
  assign bus.o_burst_cnt = burst_cnt_q;
endmodule
